load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MEM_WORDS, 64, number of 32-bit words in the downstream data memory.
REQ-002 SHALL have port: clock  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: req_valid  input  1  core presents a load/store request.
REQ-005 SHALL have port: req_ready  output  1  unit accepts a request; accept = req_valid && req_ready at a rising edge.
REQ-006 SHALL have port: req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: req_funct3  input  3  RV32I size/sign code.
REQ-008 SHALL have port: req_addr  input  32  byte address.
REQ-009 SHALL have port: req_wdata  input  32  store data, LSB-aligned.
REQ-010 SHALL have port: resp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-011 SHALL have port: resp_rdata  output  32  extended load data; 0 for stores and faults.
REQ-012 SHALL have port: resp_fault  output  1  request rejected; valid only with resp_valid.
REQ-013 SHALL have port: mem_write_enable  output  1  memory write strobe.
REQ-014 SHALL have port: mem_address  output  32  word-aligned byte address, {addr[31:2],2'b00}.
REQ-015 SHALL have port: mem_write_data  output  32  full word to write.
REQ-016 SHALL have port: mem_read_data  input  32  asynchronous read word from memory.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, MERGE, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-018 SHALL, on accept, register address, funct3, write data and next state: fault->RESP; load->LOAD; SW->WRITE; SB/SH->MERGE.
REQ-019 SHALL, in LOAD, capture the selected byte/half/word of mem_read_data, extended, at the closing edge, then enter RESP; resp_valid is high in cycle N+2 for accept cycle N.
REQ-020 SHALL, in MERGE, register mem_read_data with the addressed byte (addr[1:0]) or half (addr[1]) replaced by req_wdata[7:0]/[15:0], then enter WRITE.
REQ-021 SHALL assert mem_write_enable only in WRITE, for exactly one cycle; SW resp at N+2, SB/SH resp at N+3.
REQ-022 SHALL decode loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU (sign-extend LB/LH, zero-extend LBU/LHU); stores 000 SB, 001 SH, 010 SW; any other code SHALL fault.
REQ-023 SHALL drive mem_address = 0 and mem_write_data = 0 in IDLE and RESP.
REQ-024 SHALL, on fault, perform no memory access, assert resp_valid at N+1 with resp_fault = 1 and resp_rdata = 0.
REQ-025 SHALL return RESP->IDLE unconditionally; a new request is acceptable in the cycle after resp_valid.

Reset
REQ-026 SHALL, while reset is high, force state IDLE, req_ready 1, resp_valid 0, resp_fault 0, resp_rdata 0, mem_write_enable 0, all registers 0.
REQ-027 SHALL abort any in-flight operation on reset: no write occurs and no resp_valid is issued for it.

Configuration
REQ-028 SHALL, with LSU_FAULT_CHECK_EN defined, fault on misalignment (LH/LHU/SH addr[0]=1; LW/SW addr[1:0]!=0) and on addr[31:2] >= MEM_WORDS.
REQ-029 SHALL, without LSU_FAULT_CHECK_EN, ignore misaligned low bits (alignment forced to the access size), skip the range check, and fault only on illegal funct3.

Structure
REQ-030 SHALL place funct3 constants, the state enumeration and the data width in package lsu_pkg.
REQ-031 SHALL use one combinational sub-module, lsu_extend, for byte/half selection and sign/zero extension.

Verification
REQ-032 SHALL cover: memory word 0x8000_00F0 at 0x10; LB 0x10 -> resp_rdata 0xFFFF_FFF0 at N+2; LBU 0x10 -> 0x0000_00F0.
REQ-033 SHALL cover: word 0x1122_3344 at 0x20; SB 0x22, data 0xAA -> one write of 0x11AA_3344, resp at N+3.
REQ-034 SHALL cover: SW 0x24, 0xDEAD_BEEF -> write_enable high exactly once at N+1; subsequent LW 0x24 returns 0xDEAD_BEEF.
REQ-035 SHALL cover: with LSU_FAULT_CHECK_EN, LW 0x22 and SW 0x100 (MEM_WORDS = 64) -> resp_fault 1 at N+1, no write.
REQ-036 SHALL cover: reset asserted during MERGE of SH 0x30 -> state IDLE, no write, word at 0x30 unchanged, no resp_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: data width, RV32I size/sign codes
// and the sequencing state enumeration.
package lsu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MERGE,
    WRITE,
    RESP
  } lsu_state_t;

endpackage

// File: rtl/load_store_unit_extend.sv
// lsu_extend: picks the addressed byte/half out of a memory word and sign- or
// zero-extends it according to the load size code.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] word,
  input  logic [1:0]      byte_sel,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    byte_v = word[{byte_sel, 3'b000} +: 8];
    // Half selection uses only bit 1, so a misaligned half is forced down.
    half_v = byte_sel[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    data = {{24{byte_v[7]}}, byte_v};
      F3_H:    data = {{16{half_v[15]}}, half_v};
      F3_BU:   data = {24'd0, byte_v};
      F3_HU:   data = {16'd0, half_v};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store sequencer in front of an async-read word
// memory. Optional LSU_FAULT_CHECK_EN adds misalignment and range faults.
//
// state | meaning
// IDLE  | ready for a request
// LOAD  | memory word addressed, extended load data captured at cycle end
// MERGE | read-modify: sub-word store data folded into the current word
// WRITE | one-cycle write strobe
// RESP  | one-cycle completion pulse
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic            mem_write_enable,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_write_data,
  input  logic [XLEN-1:0] mem_read_data
);

  if (MEM_WORDS < 1 || MEM_WORDS > 1073741824) begin : g_bad_mem_words
    $error("MEM_WORDS out of range");
  end

  lsu_state_t      state;
  logic [1:0]      addr_lo_q;
  logic [2:0]      funct3_q;
  logic [15:0]     wdata_q;
  logic            fault;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] merged;

  lsu_extend u_extend (
    .word     (mem_read_data),
    .byte_sel (addr_lo_q),
    .funct3   (funct3_q),
    .data     (load_data)
  );

  always_comb begin
    if (req_write) fault = !(req_funct3 inside {F3_B, F3_H, F3_W});
    else           fault = !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
`ifdef LSU_FAULT_CHECK_EN
    if (req_funct3[1:0] == 2'b01 && req_addr[0])          fault = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) fault = 1'b1;
    if ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS))          fault = 1'b1;
`endif
  end

  always_comb begin
    merged = mem_read_data;
    if (funct3_q == F3_H) begin
      if (addr_lo_q[1]) merged[31:16] = wdata_q;
      else              merged[15:0]  = wdata_q;
    end else begin
      merged[{addr_lo_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Outputs default to their idle values each cycle; each state re-asserts
  // only what the following state must present.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      addr_lo_q        <= '0;
      funct3_q         <= '0;
      wdata_q          <= '0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_fault       <= 1'b0;
      resp_rdata       <= '0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
    end else begin
      req_ready        <= 1'b0;
      resp_valid       <= 1'b0;
      resp_fault       <= 1'b0;
      resp_rdata       <= '0;
      mem_write_enable <= 1'b0;
      mem_address      <= '0;
      mem_write_data   <= '0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr_lo_q <= req_addr[1:0];
            funct3_q  <= req_funct3;
            wdata_q   <= req_wdata[15:0];
            if (fault) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else begin
              mem_address <= {req_addr[31:2], 2'b00};
              if (!req_write) begin
                state <= LOAD;
              end else if (req_funct3 == F3_W) begin
                state            <= WRITE;
                mem_write_enable <= 1'b1;
                mem_write_data   <= req_wdata;
              end else begin
                state <= MERGE;
              end
            end
          end
        end
        LOAD: begin
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_rdata <= load_data;
        end
        MERGE: begin
          state            <= WRITE;
          mem_address      <= mem_address;
          mem_write_enable <= 1'b1;
          mem_write_data   <= merged;
        end
        WRITE: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a word-array reference model predicts
// responses and writes; a negedge monitor compares them as the DUT emits them.
module tb_load_store_unit;

  localparam int MEM_WORDS = 64;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_write_enable;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clock            (clock),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clock = ~clock;

  // Memory attached to the DUT, with a backdoor port for preloading.
  logic [31:0] mem [MEM_WORDS];
  logic        bk_we = 1'b0;
  logic [5:0]  bk_idx = 6'd0;
  logic [31:0] bk_data = 32'd0;
  assign mem_read_data = mem[mem_address[7:2]];
  always @(posedge clock) begin
    if (bk_we) mem[bk_idx] <= bk_data;
    else if (mem_write_enable) mem[mem_address[7:2]] <= mem_write_data;
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int cyc; logic flt; logic [31:0] rd; } resp_t;
  typedef struct { int cyc; logic [31:0] a; logic [31:0] d; } wr_t;
  resp_t resp_q[$];
  wr_t   wr_q[$];
  logic [31:0] ref_mem [MEM_WORDS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) fail("unexpected_resp");
        else begin
          resp_t e;
          e = resp_q.pop_front();
          chk("resp_cycle", 32'(cyc), 32'(e.cyc));
          chk("resp_fault", {31'd0, resp_fault}, {31'd0, e.flt});
          chk("resp_rdata", resp_rdata, e.rd);
          chk("resp_mem_addr_zero", mem_address, 32'd0);
          chk("resp_mem_wdata_zero", mem_write_data, 32'd0);
        end
      end else if (resp_q.size() != 0 && cyc > resp_q[0].cyc) begin
        fail("missed_resp");
        void'(resp_q.pop_front());
      end
      if (mem_write_enable) begin
        if (wr_q.size() == 0) fail("unexpected_write");
        else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("write_cycle", 32'(cyc), 32'(w.cyc));
          chk("write_addr", mem_address, w.a);
          chk("write_data", mem_write_data, w.d);
        end
      end else if (wr_q.size() != 0 && cyc > wr_q[0].cyc) begin
        fail("missed_write");
        void'(wr_q.pop_front());
      end
    end
  end

  // Reference model: architectural effect of one request on a word array.
  function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] wd, output logic flt,
                                output logic [31:0] rd, output logic [31:0] nw);
    logic [31:0] word, b, h;
    int sh8, sh16;
    if (w) flt = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else   flt = !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
`ifdef LSU_FAULT_CHECK_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && a[0]) flt = 1'b1;
    if (f3 == 3'd2 && a[1:0] != 2'd0) flt = 1'b1;
    if ((a >> 2) >= MEM_WORDS) flt = 1'b1;
`endif
    rd = 32'd0;
    word = ref_mem[a[7:2]];
    nw = word;
    sh8  = 8 * int'(a[1:0]);
    sh16 = 16 * int'(a[1]);
    b = (word >> sh8) & 32'hFF;
    h = (word >> sh16) & 32'hFFFF;
    if (!flt && !w) begin
      case (f3)
        3'd0: rd = (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
        3'd1: rd = (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
        3'd4: rd = b;
        3'd5: rd = h;
        default: rd = word;
      endcase
    end
    if (!flt && w) begin
      case (f3)
        3'd0: nw = (word & ~(32'hFF << sh8)) | ((wd & 32'hFF) << sh8);
        3'd1: nw = (word & ~(32'hFFFF << sh16)) | ((wd & 32'hFFFF) << sh16);
        default: nw = wd;
      endcase
    end
  endfunction

  // Called just after a falling edge while the DUT is idle; returns just after
  // the falling edge of the cycle following the response.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    logic flt;
    logic [31:0] rd, nw;
    resp_t r;
    wr_t   x;
    model(w, f3, a, wd, flt, rd, nw);
    req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    r.cyc = cyc + (flt ? 1 : (w && f3 != 3'd2) ? 3 : 2);
    r.flt = flt;
    r.rd  = rd;
    resp_q.push_back(r);
    if (w && !flt) begin
      x.cyc = cyc + ((f3 == 3'd2) ? 1 : 2);
      x.a = {a[31:2], 2'b00};
      x.d = nw;
      wr_q.push_back(x);
      ref_mem[a[7:2]] = nw;
    end
    @(posedge clock);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 10 && resp_q.size() != 0; k++) begin
      @(negedge clock);
      #1;
    end
    if (resp_q.size() != 0) begin
      fail("resp_timeout");
      resp_q.delete();
      wr_q.delete();
    end else begin
      chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
    end
    @(negedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    logic [31:0] saved;
    for (int i = 0; i < MEM_WORDS; i++) begin
      @(negedge clock);
      v = (i == 4) ? 32'h8000_00F0 : (i == 8) ? 32'h1122_3344 : $urandom;
      bk_we = 1'b1; bk_idx = 6'(i); bk_data = v;
      ref_mem[i] = v;
    end
    @(negedge clock);
    bk_we = 1'b0;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_fault", {31'd0, resp_fault}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_write_enable}, 32'd0);
    chk("rst_mem_addr", mem_address, 32'd0);
    chk("rst_mem_wdata", mem_write_data, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    #1;

    issue(1'b0, 3'd0, 32'h10, 32'h0);          // LB  -> FFFF_FFF0
    issue(1'b0, 3'd4, 32'h10, 32'h0);          // LBU -> 0000_00F0
    issue(1'b1, 3'd0, 32'h22, 32'h0000_00AA);  // SB
    chk("sb_mem_word", mem[8], 32'h11AA_3344);
    issue(1'b1, 3'd2, 32'h24, 32'hDEAD_BEEF);  // SW
    issue(1'b0, 3'd2, 32'h24, 32'h0);          // LW -> DEAD_BEEF
    issue(1'b0, 3'd3, 32'h10, 32'h0);          // illegal load code
    issue(1'b1, 3'd4, 32'h10, 32'h1234_5678);  // illegal store code
`ifdef LSU_FAULT_CHECK_EN
    issue(1'b0, 3'd2, 32'h22, 32'h0);
    issue(1'b1, 3'd2, 32'h100, 32'h5555_AAAA);
`else
    issue(1'b0, 3'd1, 32'h23, 32'h0);          // misaligned LH forced to half 1
`endif

    // Reset while an SH sits in MERGE: nothing may be written or answered.
    saved = mem[12];
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd1;
    req_addr = 32'h30; req_wdata = $urandom;
    @(posedge clock);
    #1 req_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("abort_req_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("abort_mem_we", {31'd0, mem_write_enable}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk("abort_mem_unchanged", mem[12], saved);
    #1;

    for (int n = 0; n < 150; n++) begin
      logic w;
      logic [2:0] f3;
      logic [31:0] a;
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
`ifdef LSU_FAULT_CHECK_EN
      a = 32'($urandom_range(0, 319));
`else
      a = 32'($urandom_range(0, 255));
`endif
      issue(w, f3, a, $urandom);
    end

    for (int i = 0; i < MEM_WORDS; i += 7) chk("final_mem", mem[i], ref_mem[i]);
    chk("pending_writes", 32'(wr_q.size()), 32'd0);
    chk("pending_resps", 32'(resp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
